mux4_scan_ctrl: RTL and testbench
=================================

// Module: mux4_scan_ctrl
// PURPOSE
//  Upstream sequencer for the 4:1 mux user project. On start it steps the mux select through
//  the enabled channels in ascending order and waits a programmable settle time on each one.
//  It then samples the mux output and presents {channel, data} on a valid/ready stream.
//  Supports single-pass and continuous scanning. Sits between the tile IO/control logic and the mux.
// PARAMETERS
//  DATA_W   1   width of mux output sample (mux_y / out_data)
//  DWELL_W  8   width of settle-count input dwell
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        begin a scan pass (level sampled each cycle; ignored while busy)
//  cont       in   1        1 = restart a new pass automatically at end of pass
//  chan_en    in   4        channel enable mask, latched on accepted start / auto-restart
//  dwell      in   DWELL_W  settle cycles per channel, latched with chan_en; 0 treated as 1
//  sel        out  2        mux select driven to the 4:1 mux
//  mux_y      in   DATA_W   mux output being sampled
//  out_valid  out  1        sample available
//  out_ready  in   1        consumer accepts sample
//  out_chan   out  2        channel index of sample
//  out_data   out  DATA_W   sampled mux_y
//  busy       out  1        scan pass in progress
//  done       out  1        one-cycle pulse at end of each pass
// BEHAVIOUR
//  - Reset values: sel=0, out_valid=0, out_chan=0, out_data=0, busy=0, done=0, state=IDLE, cnt=0.
//    rst takes priority over all other inputs and aborts any pass mid-operation; a pending sample is dropped.
//  - FSM: IDLE -> SETTLE -> HOLD -> (SETTLE | IDLE).
//  - IDLE: when start=1 at edge k, latch chan_en/dwell. If mask!=0: at k+1 sel=lowest enabled ch,
//    cnt=1, busy=1, state=SETTLE. If mask==0: done=1 at k+1 only, stay IDLE, no sample.
//  - SETTLE: cnt increments each cycle. At the edge where cnt==max(dwell,1), out_data<=mux_y,
//    out_chan<=sel, out_valid<=1, state=HOLD. First out_valid rises at k+1+max(dwell,1).
//  - HOLD: out_valid, out_chan, out_data and sel stay stable while out_ready=0.
//    On edge with out_valid&&out_ready: out_valid<=0. If a higher enabled ch exists: sel<=it, cnt=1, SETTLE.
//    Otherwise end of pass: done=1 for one cycle, and
//      cont=1 -> re-latch chan_en/dwell and restart as from IDLE; busy stays 1.
//                A new mask of 0 ends the scan: busy=0.
//      cont=0 -> busy=0, IDLE; sel holds last channel.
//  - No bubbles beyond the settle time: the next channel's cnt=1 cycle coincides with the handshake cycle+1.
//  - start asserted while busy is ignored. chan_en/dwell changes mid-pass have no effect until the next latch.
//  - Counter is DWELL_W bits, compared against dwell; it never wraps because dwell<=2^DWELL_W-1.
//  - out_ready while out_valid=0 has no effect.
// STRUCTURE
//  - Package mux4_scan_pkg: state enum {IDLE,SETTLE,HOLD}, localparam CH_N=4, SEL_W=2.
//  - Sub-module mux4_next_chan (combinational): given mask[3:0] and current sel, returns
//    found flag and lowest enabled ch > sel. It is used both for the first channel and for advancing.
//  - Top: FSM, settle counter, latched config, output registers. All state is held in flops clocked on clk.
// TESTING
//  1. rst, chan_en=4'b1111, dwell=3, start pulse, out_ready=1, mux_y=ch[0] -> samples ch0..3 in
//     order, first out_valid 4 cycles after start edge, data=sel[0], done pulse after ch3, busy=0.
//  2. chan_en=4'b1010, dwell=0 -> only ch1 and ch3 emitted; each settles 1 cycle; done once.
//  3. chan_en=4'b0001, out_ready held 0 for 10 cycles -> out_valid and out_data stable; sel=0 held;
//     completes one cycle after out_ready=1.
//  4. chan_en=0, start -> done pulse next cycle, out_valid never asserts, busy stays 0.
//  5. cont=1, chan_en=4'b0110, dwell=2 -> repeating ch1,ch2,ch1,...; done each pass; busy stays 1;
//     drop cont -> stops after the current pass.
//  6. rst asserted in HOLD on ch2 -> next cycle all outputs equal reset values; start while busy ignored.

Source files
------------

// File: rtl/mux4_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux4_scan_pkg;

  localparam int CH_N  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/mux4_next_chan.sv
// Combinational search: lowest enabled channel strictly above the current select.
module mux4_next_chan
  import mux4_scan_pkg::*;
(
  input  logic [CH_N-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  output logic             found,
  output logic [SEL_W-1:0] chan
);

  logic [CH_N-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < CH_N; gi++) begin : g_cand
      assign cand[gi] = mask[gi] && (SEL_W'(gi) > cur);
    end
  endgenerate

  // Scan downwards so the lowest candidate is the last one written.
  always_comb begin
    found = 1'b0;
    chan  = '0;
    for (int i = CH_N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found = 1'b1;
        chan  = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer: steps the mux select over enabled channels, settles, samples, streams {chan, data}.
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic [CH_N-1:0]    chan_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  input  logic [DATA_W-1:0]  mux_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_chan,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy,
  output logic               done
);

  state_e             state_reg;
  logic [DWELL_W-1:0] cnt_reg;
  logic [CH_N-1:0]    mask_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic               out_valid_reg;
  logic [SEL_W-1:0]   out_chan_reg;
  logic [DATA_W-1:0]  out_data_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               adv_found;
  logic [SEL_W-1:0]   adv_chan;
  logic               up_found;
  logic [SEL_W-1:0]   up_chan;
  logic               first_any;
  logic [SEL_W-1:0]   first_chan;
  logic [DWELL_W-1:0] dwell_eff;

  // Advance within the latched mask of the running pass.
  mux4_next_chan u_adv (
    .mask  (mask_reg),
    .cur   (sel_reg),
    .found (adv_found),
    .chan  (adv_chan)
  );

  // First channel of a new pass comes from the live mask being latched; channel 0 is checked directly.
  mux4_next_chan u_first (
    .mask  (chan_en),
    .cur   ({SEL_W{1'b0}}),
    .found (up_found),
    .chan  (up_chan)
  );

  assign first_any  = chan_en[0] | up_found;
  assign first_chan = chan_en[0] ? '0 : up_chan;
  assign dwell_eff  = (dwell_reg == '0) ? DWELL_W'(1) : dwell_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mask_reg      <= '0;
      dwell_reg     <= '0;
      sel_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_chan_reg  <= '0;
      out_data_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mask_reg  <= chan_en;
            dwell_reg <= dwell;
            if (first_any) begin
              sel_reg   <= first_chan;
              cnt_reg   <= DWELL_W'(1);
              busy_reg  <= 1'b1;
              state_reg <= SETTLE;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end

        SETTLE: begin
          if (cnt_reg == dwell_eff) begin
            out_data_reg  <= mux_y;
            out_chan_reg  <= sel_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else begin
            cnt_reg <= cnt_reg + DWELL_W'(1);
          end
        end

        HOLD: begin
          if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
            if (adv_found) begin
              sel_reg   <= adv_chan;
              cnt_reg   <= DWELL_W'(1);
              state_reg <= SETTLE;
            end else begin
              done_reg <= 1'b1;
              if (cont) begin
                mask_reg  <= chan_en;
                dwell_reg <= dwell;
                if (first_any) begin
                  sel_reg   <= first_chan;
                  cnt_reg   <= DWELL_W'(1);
                  state_reg <= SETTLE;
                end else begin
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
                end
              end else begin
                busy_reg  <= 1'b0;
                state_reg <= IDLE;
              end
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sel       = sel_reg;
  assign out_valid = out_valid_reg;
  assign out_chan  = out_chan_reg;
  assign out_data  = out_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl; a small 4:1 mux model feeds mux_y from sel.
module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic [3:0] chan_en;
  logic [7:0] dwell;
  logic [1:0] sel;
  logic [0:0] mux_y;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_chan;
  logic [0:0] out_data;
  logic       busy;
  logic       done;
  logic [3:0] mux_in;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mux_y = mux_in[sel];

  mux4_scan_ctrl #(.DATA_W(1), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cont      (cont),
    .chan_en   (chan_en),
    .dwell     (dwell),
    .sel       (sel),
    .mux_y     (mux_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; chan_en = 4'h0; dwell = 8'd0;
    out_ready = 1'b0; mux_in = 4'b1010;
    step(); step();
    chk("rst_sel", sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();
    $display("reset released: sel=%0d busy=%0d", sel, busy);

    // 1: all channels, dwell 3, always ready
    chan_en = 4'b1111; dwell = 8'd3; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_sel0", sel, 0);
    for (int ch = 0; ch < 4; ch++) begin
      step(); step();
      chk("t1_early", out_valid, 0);
      step();
      chk("t1_valid", out_valid, 1);
      chk("t1_chan", out_chan, ch);
      chk("t1_data", out_data, ch & 1);
      chk("t1_sel", sel, ch);
      $display("t1 sample chan=%0d data=%0d", out_chan, out_data);
      step();
      chk("t1_drop", out_valid, 0);
      if (ch < 3) begin
        chk("t1_next", sel, ch + 1);
        chk("t1_nodone", done, 0);
        chk("t1_busy_mid", busy, 1);
      end else begin
        chk("t1_done", done, 1);
        chk("t1_idle", busy, 0);
        chk("t1_sel_hold", sel, 3);
      end
    end
    step();
    chk("t1_done_pulse", done, 0);

    // 2: sparse mask, dwell 0 treated as 1; mid-pass mask change must not matter
    chan_en = 4'b1010; dwell = 8'd0; start = 1'b1;
    step();
    start = 1'b0; chan_en = 4'b0100;
    chk("t2_sel1", sel, 1);
    step();
    chk("t2_v1", out_valid, 1);
    chk("t2_c1", out_chan, 1);
    chk("t2_d1", out_data, 1);
    $display("t2 sample chan=%0d data=%0d", out_chan, out_data);
    step();
    chk("t2_drop", out_valid, 0);
    chk("t2_sel3", sel, 3);
    chk("t2_nodone", done, 0);
    step();
    chk("t2_v3", out_valid, 1);
    chk("t2_c3", out_chan, 3);
    chk("t2_d3", out_data, 1);
    $display("t2 sample chan=%0d data=%0d", out_chan, out_data);
    step();
    chk("t2_done", done, 1);
    chk("t2_idle", busy, 0);
    step();
    chk("t2_done_once", done, 0);
    chk("t2_novalid", out_valid, 0);

    // 3: backpressure on channel 0; mux input changes during hold must not leak
    chan_en = 4'b0001; dwell = 8'd1; out_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_sel", sel, 0);
    step();
    chk("t3_valid", out_valid, 1);
    chk("t3_data", out_data, 0);
    mux_in = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data", out_data, 0);
      chk("t3_hold_sel", sel, 0);
      chk("t3_hold_chan", out_chan, 0);
    end
    $display("t3 held chan=%0d data=%0d for 10 cycles", out_chan, out_data);
    out_ready = 1'b1;
    step();
    chk("t3_accept", out_valid, 0);
    chk("t3_done", done, 1);
    chk("t3_idle", busy, 0);
    mux_in = 4'b1010;

    // 4: empty mask
    chan_en = 4'b0000; start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_quiet_done", done, 0);
      chk("t4_quiet_valid", out_valid, 0);
      chk("t4_quiet_busy", busy, 0);
    end
    $display("t4 empty mask done");

    // 5: continuous scan over ch1,ch2 with dwell 2; cont dropped during third pass
    cont = 1'b1; chan_en = 4'b0110; dwell = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_sel", sel, 1);
    chk("t5_busy", busy, 1);
    for (int p = 0; p < 3; p++) begin
      if (p == 2) cont = 1'b0;
      for (int c = 1; c <= 2; c++) begin
        step();
        chk("t5_early", out_valid, 0);
        step();
        chk("t5_valid", out_valid, 1);
        chk("t5_chan", out_chan, c);
        chk("t5_data", out_data, c & 1);
        $display("t5 pass=%0d sample chan=%0d data=%0d", p, out_chan, out_data);
        step();
        chk("t5_drop", out_valid, 0);
        if (c == 1) begin
          chk("t5_nodone", done, 0);
          chk("t5_sel2", sel, 2);
        end else begin
          chk("t5_done", done, 1);
          chk("t5_busy_end", busy, (p < 2) ? 1 : 0);
          chk("t5_sel_end", sel, (p < 2) ? 1 : 2);
        end
      end
    end
    step();
    chk("t5_stopped", busy, 0);
    chk("t5_no_more", done, 0);

    // 6: reset while holding a sample on ch2; start while busy ignored
    chan_en = 4'b0100; dwell = 8'd1; out_ready = 1'b0; mux_in = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_sel", sel, 2);
    step();
    chk("t6_valid", out_valid, 1);
    chk("t6_chan", out_chan, 2);
    chk("t6_data", out_data, 1);
    chan_en = 4'b0001; start = 1'b1;
    step();
    chk("t6_ign_valid", out_valid, 1);
    chk("t6_ign_sel", sel, 2);
    chk("t6_ign_chan", out_chan, 2);
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("t6_rst_sel", sel, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_chan", out_chan, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    step();
    chk("t6_after_valid", out_valid, 0);
    chk("t6_after_busy", busy, 0);
    $display("t6 reset in hold: sel=%0d valid=%0d busy=%0d", sel, out_valid, busy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
